// File: rtl/axi_addr_issue_pkg.sv
// Shared widths, constants and state encoding for the AXI address-channel initiator.
package axi_addr_issue_pkg;

   localparam int unsigned ID_BITS    = 4;
   localparam int unsigned LEN_BITS   = 4;
   localparam int unsigned SIZE_BITS  = 3;
   localparam int unsigned BURST_BITS = 2;
   localparam int unsigned LOCK_BITS  = 2;
   localparam int unsigned CACHE_BITS = 4;
   localparam int unsigned PROT_BITS  = 3;

   // 4 KB page offset width and the 13-bit width needed to represent a full page
   localparam int unsigned PAGE_BITS  = 12;
   localparam int unsigned SPLIT_BITS = 13;

   localparam logic [BURST_BITS-1:0] BURST_INCR = 2'b01;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CALC  = 2'd1,
      ISSUE = 2'd2,
      FIN   = 2'd3
   } state_e;

endpackage

// File: rtl/axi_burst_len.sv
// Beats in the next INCR burst: min(beats left, beats to the 4 KB page end, max burst).
module axi_burst_len
   import axi_addr_issue_pkg::*;
#(
   parameter int unsigned p_size  = 4,
   parameter int unsigned beats_w = 20,
   parameter int unsigned n_w     = 5
) (
   input  logic [PAGE_BITS-1:0] addr_lo_i,
   input  logic [beats_w-1:0]   beats_left_i,
   input  logic [n_w-1:0]       max_beats_i,
   output logic [n_w-1:0]       n_c_o
);

   localparam int unsigned CW = (beats_w > SPLIT_BITS) ? beats_w : SPLIT_BITS;

   logic [SPLIT_BITS-1:0] to_4k;
   logic [CW-1:0]         n_min;

   // Three-way minimum; 13-bit page arithmetic so an aligned page start yields a full page
   always_comb begin
      to_4k = (SPLIT_BITS'(4096) - {1'b0, addr_lo_i}) >> p_size;
      n_min = CW'(beats_left_i);
      if (CW'(to_4k) < n_min) n_min = CW'(to_4k);
      if (CW'(max_beats_i) < n_min) n_min = CW'(max_beats_i);
      n_c_o = n_w'(n_min);
   end

endmodule

// File: rtl/axi_addr_issue.sv
// Splits a linear transfer request into 4 KB-safe INCR bursts on an AXI address channel.
module axi_addr_issue
   import axi_addr_issue_pkg::*;
#(
   parameter int unsigned masters   = 4,
   parameter int unsigned width     = 32,
   parameter int unsigned p_size    = 4,
   parameter int unsigned max_beats = 16,
   parameter int unsigned cnt_bits  = 24
) (
   input  logic                  CLK,
   input  logic                  RESETN,
   input  logic                  REQ_VALID,
   output logic                  REQ_READY,
   input  logic [masters-1:0]    REQ_MASTER,
   input  logic [ID_BITS-1:0]    REQ_ID,
   input  logic [width-1:0]      REQ_ADDR,
   input  logic [cnt_bits-1:0]   REQ_BYTES,
   output logic [masters-1:0]    O_MASTER,
   output logic [ID_BITS-1:0]    ID,
   output logic [width-1:0]      ADDR,
   output logic [LEN_BITS-1:0]   LEN,
   output logic [SIZE_BITS-1:0]  SIZE,
   output logic [BURST_BITS-1:0] BURST,
   output logic [LOCK_BITS-1:0]  LOCK,
   output logic [CACHE_BITS-1:0] CACHE,
   output logic [PROT_BITS-1:0]  PROT,
   output logic                  VALID,
   input  logic                  READY,
   output logic                  DONE,
   output logic                  BUSY
);

   localparam int unsigned BEATS_W = cnt_bits - p_size;
   localparam int unsigned NW      = LEN_BITS + 1;

   state_e               state_q, state_d;
   logic                 req_ready_q, valid_q, done_q, busy_q;
   logic [width-1:0]     addr_q, addr_d;
   logic [LEN_BITS-1:0]  len_q, len_d;
   logic [ID_BITS-1:0]   id_q, id_d;
   logic [masters-1:0]   master_q, master_d;
   logic [width-1:0]     cur_addr_q, cur_addr_d;
   logic [BEATS_W-1:0]   beats_left_q, beats_left_d;
   logic [NW-1:0]        burst_n;
   logic [NW-1:0]        issued_n;
   logic [BEATS_W-1:0]   req_beats;
   logic                 unused_lo;

   // Byte offsets below the bus width are dropped
   assign req_beats = REQ_BYTES[cnt_bits-1:p_size];
   assign unused_lo = ^{REQ_ADDR[p_size-1:0], REQ_BYTES[p_size-1:0]};
   assign issued_n  = NW'(len_q) + NW'(1);

   axi_burst_len #(
      .p_size  (p_size),
      .beats_w (BEATS_W),
      .n_w     (NW)
   ) u_burst_len (
      .addr_lo_i    (cur_addr_q[PAGE_BITS-1:0]),
      .beats_left_i (beats_left_q),
      .max_beats_i  (NW'(max_beats)),
      .n_c_o        (burst_n)
   );

   // Next-state and datapath updates
   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      len_d        = len_q;
      id_d         = id_q;
      master_d     = master_q;
      cur_addr_d   = cur_addr_q;
      beats_left_d = beats_left_q;
      case (state_q)
         IDLE: begin
            if (REQ_VALID && req_ready_q) begin
               id_d         = REQ_ID;
               master_d     = REQ_MASTER;
               cur_addr_d   = {REQ_ADDR[width-1:p_size], {p_size{1'b0}}};
               beats_left_d = req_beats;
               state_d      = (req_beats == '0) ? FIN : CALC;
            end
         end
         CALC: begin
            addr_d  = cur_addr_q;
            len_d   = LEN_BITS'(burst_n - NW'(1));
            state_d = ISSUE;
         end
         ISSUE: begin
            if (READY) begin
               cur_addr_d   = cur_addr_q + (width'(issued_n) << p_size);
               beats_left_d = beats_left_q - BEATS_W'(issued_n);
               state_d      = (beats_left_q == BEATS_W'(issued_n)) ? FIN : CALC;
            end
         end
         FIN: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and registered outputs; handshake flags follow the next state
   always_ff @(posedge CLK) begin
      if (!RESETN) begin
         state_q      <= IDLE;
         req_ready_q  <= 1'b0;
         valid_q      <= 1'b0;
         done_q       <= 1'b0;
         busy_q       <= 1'b0;
         addr_q       <= '0;
         len_q        <= '0;
         id_q         <= '0;
         master_q     <= '0;
         cur_addr_q   <= '0;
         beats_left_q <= '0;
      end else begin
         state_q      <= state_d;
         req_ready_q  <= (state_d == IDLE);
         valid_q      <= (state_d == ISSUE);
         done_q       <= (state_d == FIN);
         busy_q       <= (state_d != IDLE);
         addr_q       <= addr_d;
         len_q        <= len_d;
         id_q         <= id_d;
         master_q     <= master_d;
         cur_addr_q   <= cur_addr_d;
         beats_left_q <= beats_left_d;
      end
   end

   assign REQ_READY = req_ready_q;
   assign VALID     = valid_q;
   assign DONE      = done_q;
   assign BUSY      = busy_q;
   assign ADDR      = addr_q;
   assign LEN       = len_q;
   assign ID        = id_q;
   assign O_MASTER  = master_q;
   assign SIZE      = SIZE_BITS'(p_size);
   assign BURST     = BURST_INCR;
   assign LOCK      = '0;
   assign CACHE     = '0;
   assign PROT      = '0;

endmodule

// File: tb/tb_axi_addr_issue.sv
// Randomized self-checking bench for axi_addr_issue against a burst-list reference model.
module tb_axi_addr_issue;
   import axi_addr_issue_pkg::*;

   localparam int unsigned MASTERS   = 4;
   localparam int unsigned WIDTH     = 32;
   localparam int unsigned P_SIZE    = 4;
   localparam int unsigned MAX_BEATS = 16;
   localparam int unsigned CNT_BITS  = 24;

   logic                  CLK = 1'b0;
   logic                  RESETN = 1'b0;
   logic                  REQ_VALID = 1'b0;
   logic                  REQ_READY;
   logic [MASTERS-1:0]    REQ_MASTER = '0;
   logic [ID_BITS-1:0]    REQ_ID = '0;
   logic [WIDTH-1:0]      REQ_ADDR = '0;
   logic [CNT_BITS-1:0]   REQ_BYTES = '0;
   logic [MASTERS-1:0]    O_MASTER;
   logic [ID_BITS-1:0]    ID;
   logic [WIDTH-1:0]      ADDR;
   logic [LEN_BITS-1:0]   LEN;
   logic [SIZE_BITS-1:0]  SIZE;
   logic [BURST_BITS-1:0] BURST;
   logic [LOCK_BITS-1:0]  LOCK;
   logic [CACHE_BITS-1:0] CACHE;
   logic [PROT_BITS-1:0]  PROT;
   logic                  VALID;
   logic                  READY = 1'b0;
   logic                  DONE;
   logic                  BUSY;

   int n_checks = 0;
   int n_fail   = 0;

   longint unsigned q_addr[$];
   int unsigned     q_len[$];

   axi_addr_issue #(
      .masters   (MASTERS),
      .width     (WIDTH),
      .p_size    (P_SIZE),
      .max_beats (MAX_BEATS),
      .cnt_bits  (CNT_BITS)
   ) dut (
      .CLK        (CLK),
      .RESETN     (RESETN),
      .REQ_VALID  (REQ_VALID),
      .REQ_READY  (REQ_READY),
      .REQ_MASTER (REQ_MASTER),
      .REQ_ID     (REQ_ID),
      .REQ_ADDR   (REQ_ADDR),
      .REQ_BYTES  (REQ_BYTES),
      .O_MASTER   (O_MASTER),
      .ID         (ID),
      .ADDR       (ADDR),
      .LEN        (LEN),
      .SIZE       (SIZE),
      .BURST      (BURST),
      .LOCK       (LOCK),
      .CACHE      (CACHE),
      .PROT       (PROT),
      .VALID      (VALID),
      .READY      (READY),
      .DONE       (DONE),
      .BUSY       (BUSY)
   );

   always #5 CLK = ~CLK;

   // Single comparison point: counts every check and reports mismatches
   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   // Reference: walk the transfer, cutting at page ends and at the burst cap
   function automatic void model(input longint unsigned addr, input longint unsigned bytes);
      longint unsigned a, beats, to4k, n;
      q_addr.delete();
      q_len.delete();
      a     = addr - (addr % 16);
      beats = bytes / 16;
      while (beats > 0) begin
         to4k = (4096 - (a % 4096)) / 16;
         n = beats;
         if (to4k < n) n = to4k;
         if (64'(MAX_BEATS) < n) n = 64'(MAX_BEATS);
         q_addr.push_back(a);
         q_len.push_back(32'(n - 1));
         a     = (a + n * 16) % (64'd1 << WIDTH);
         beats = beats - n;
      end
   endfunction

   task automatic run_req(input logic [31:0] addr, input logic [23:0] bytes,
                          input int stall_min, input int stall_max, input int abort_after);
      int k;
      int s;
      logic [ID_BITS-1:0] id;
      logic [MASTERS-1:0] mst;
      id  = ID_BITS'($urandom);
      mst = MASTERS'($urandom);
      k = 0;
      while (REQ_READY !== 1'b1 && k < 20) begin
         step();
         k++;
      end
      chk("req_ready_idle", 64'(REQ_READY), 64'(1));
      REQ_VALID  = 1'b1;
      REQ_ADDR   = addr;
      REQ_BYTES  = bytes;
      REQ_ID     = id;
      REQ_MASTER = mst;
      step();
      REQ_VALID  = 1'b0;
      REQ_ADDR   = $urandom;
      REQ_BYTES  = CNT_BITS'($urandom);
      REQ_ID     = ID_BITS'($urandom);
      REQ_MASTER = MASTERS'($urandom);
      chk("busy_after_accept", 64'(BUSY), 64'(1));
      chk("req_ready_busy", 64'(REQ_READY), 64'(0));
      model(64'(addr), 64'(bytes));
      if (q_addr.size() == 0) begin
         chk("zero_done", 64'(DONE), 64'(1));
         chk("zero_valid", 64'(VALID), 64'(0));
         step();
         chk("zero_done_end", 64'(DONE), 64'(0));
         chk("zero_busy_end", 64'(BUSY), 64'(0));
         chk("zero_ready_back", 64'(REQ_READY), 64'(1));
         return;
      end
      for (int i = 0; i < q_addr.size(); i++) begin
         chk("gap_valid_low", 64'(VALID), 64'(0));
         chk("gap_done_low", 64'(DONE), 64'(0));
         READY = 1'($urandom);
         step();
         READY = 1'b0;
         chk("valid_rise", 64'(VALID), 64'(1));
         chk("addr", 64'(ADDR), q_addr[i]);
         chk("len", 64'(LEN), 64'(q_len[i]));
         chk("id", 64'(ID), 64'(id));
         chk("master", 64'(O_MASTER), 64'(mst));
         chk("attrs", 64'({SIZE, BURST, LOCK, CACHE, PROT}),
             64'({3'(P_SIZE), 2'b01, 2'b00, 4'b0000, 3'b000}));
         chk("no_4k_cross", 64'((32'(ADDR[11:0]) + (32'(LEN) + 1) * 16) <= 4096), 64'(1));
         s = $urandom_range(stall_max, stall_min);
         for (int j = 0; j < s; j++) begin
            step();
            chk("stall_valid", 64'(VALID), 64'(1));
            chk("stall_addr", 64'(ADDR), q_addr[i]);
            chk("stall_len", 64'(LEN), 64'(q_len[i]));
            chk("stall_done", 64'(DONE), 64'(0));
         end
         READY = 1'b1;
         step();
         READY = 1'b0;
         if (i == abort_after) begin
            RESETN = 1'b0;
            step();
            RESETN = 1'b1;
            chk("abort_valid", 64'(VALID), 64'(0));
            chk("abort_busy", 64'(BUSY), 64'(0));
            chk("abort_done", 64'(DONE), 64'(0));
            chk("abort_ready", 64'(REQ_READY), 64'(0));
            chk("abort_addr", 64'(ADDR), 64'(0));
            chk("abort_len", 64'(LEN), 64'(0));
            for (int j = 0; j < 4; j++) begin
               step();
               chk("abort_quiet", 64'({VALID, DONE}), 64'(0));
            end
            return;
         end
      end
      chk("done_pulse", 64'(DONE), 64'(1));
      chk("done_valid_low", 64'(VALID), 64'(0));
      chk("done_busy", 64'(BUSY), 64'(1));
      step();
      chk("done_end", 64'(DONE), 64'(0));
      chk("busy_end", 64'(BUSY), 64'(0));
      chk("ready_back", 64'(REQ_READY), 64'(1));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] a;
      logic [23:0] b;
      RESETN = 1'b0;
      step();
      step();
      chk("rst_outputs", 64'({VALID, DONE, BUSY, REQ_READY}), 64'(0));
      chk("rst_addr", 64'(ADDR), 64'(0));
      chk("rst_len", 64'(LEN), 64'(0));
      chk("rst_id_master", 64'({ID, O_MASTER}), 64'(0));
      RESETN = 1'b1;
      step();
      chk("ready_after_rst", 64'(REQ_READY), 64'(1));

      run_req(32'h0000_1000, 24'd256, 0, 0, -1);
      run_req(32'h0000_1F80, 24'd512, 0, 2, -1);
      run_req(32'h0000_3000, 24'd0, 0, 0, -1);
      run_req(32'h0000_3000, 24'h00000F, 0, 0, -1);
      run_req(32'h0000_1000, 24'd256, 5, 5, -1);
      run_req(32'h0000_100C, 24'h000020, 0, 1, -1);
      run_req(32'h0000_1F80, 24'd512, 0, 1, 0);
      run_req(32'h0000_1000, 24'd256, 0, 0, -1);
      run_req(32'hFFFF_FF00, 24'd512, 0, 1, -1);

      for (int r = 0; r < 40; r++) begin
         a = $urandom;
         if ($urandom_range(1, 0) == 1) a[11:8] = 4'hF;
         b = 24'($urandom_range((r % 4 == 0) ? 4200 : 1100, 0));
         run_req(a, b, 0, 3, -1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
